// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two caches, the arbiter and the RAM.
// The slave view is the arbiter; the master view drives requests and RAM replies.
interface mem_arbiter_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic              ram_rdy;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ramload, ram_rdy,
    output iwait, iload, dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    output ramload, ram_rdy,
    input  iwait, iload, dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Icache/dcache to single-port RAM arbiter, dcache priority with icache starvation guard.
// Define ARB_STATS_EN to add grant and stall statistics counters.
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] igrant_cnt,
  output logic [31:0] dgrant_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } state_e;

  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          d_req;
  logic          i_done;
  logic          d_done;
  logic          i_gnt;
  logic          d_gnt;

  assign d_req = bus.dREN | bus.dWEN;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    i_done   = 1'b0;
    d_done   = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(bus.iREN && starve_q == SMAX)) begin
          state_d = DGNT;
          d_gnt   = 1'b1;
          if (!bus.iREN)
            starve_d = '0;
          else if (starve_q != SMAX)
            starve_d = starve_q + SW'(1);
        end else if (bus.iREN) begin
          state_d  = IGNT;
          i_gnt    = 1'b1;
          starve_d = '0;
        end
      end
      IGNT: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ram_rdy) begin
          i_done  = 1'b1;
          state_d = IDLE;
        end
      end
      DGNT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else if (bus.ram_rdy) begin
          d_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // RAM side is selected by the grant state only
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    unique case (state_q)
      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      DGNT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: ;
    endcase
  end

  assign bus.iwait = ~i_done;
  assign bus.dwait = ~d_done;
  assign bus.iload = i_done ? bus.ramload : '0;
  assign bus.dload = d_done ? bus.ramload : '0;

`ifdef ARB_STATS_EN
  logic [31:0] igrant_q, igrant_d;
  logic [31:0] dgrant_q, dgrant_d;
  logic [31:0] stall_q, stall_d;
  logic        stall;

  always_comb begin
    stall    = (bus.iREN & bus.iwait) | (d_req & bus.dwait);
    igrant_d = igrant_q + {31'd0, i_gnt};
    dgrant_d = dgrant_q + {31'd0, d_gnt};
    stall_d  = stall_q + {31'd0, stall};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      igrant_q <= '0;
      dgrant_q <= '0;
      stall_q  <= '0;
    end else begin
      igrant_q <= igrant_d;
      dgrant_q <= dgrant_d;
      stall_q  <= stall_d;
    end
  end

  assign igrant_cnt = igrant_q;
  assign dgrant_cnt = dgrant_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, starvation guard, writes, reset, stats.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam int A = 32;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  mem_arbiter_if #(.WORD_W(W), .ADDR_W(A)) bus ();

`ifdef ARB_STATS_EN
  logic [31:0] igc, dgc, stc;
`endif

  mem_arbiter #(
    .WORD_W(W),
    .ADDR_W(A),
    .STARVE_MAX(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef ARB_STATS_EN
    ,
    .igrant_cnt(igc),
    .dgrant_cnt(dgc),
    .stall_cnt(stc)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts dcache grants until the icache is granted, completing each one.
  task automatic run_starve(output int n_d, output bit got_i);
    n_d   = 0;
    got_i = 1'b0;
    for (int k = 0; k < 10 && !got_i; k++) begin
      tick();
      #1;
      if (bus.ramWEN) begin
        n_d++;
        bus.ram_rdy = 1'b1;
        #1;
        tick();
        bus.ram_rdy = 1'b0;
        #1;
      end else if (bus.ramREN) begin
        got_i = 1'b1;
        check("t3 iaddr", bus.ramaddr, 64'h44);
        bus.ram_rdy = 1'b1;
        #1;
        check("t3 idone", bus.iwait, 0);
        tick();
        bus.ram_rdy = 1'b0;
        #1;
      end
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic txn(input bit is_d);
    if (is_d) bus.dREN = 1'b1;
    else      bus.iREN = 1'b1;
    #1;
    tick();
    tick();
    bus.ram_rdy = 1'b1;
    #1;
    tick();
    bus.ram_rdy = 1'b0;
    bus.iREN    = 1'b0;
    bus.dREN    = 1'b0;
    #1;
  endtask
`endif

  int n_d;
  bit got_i;

  initial begin
    RST          = 1'b1;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ram_rdy  = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    #1;
    check("rst iwait", bus.iwait, 1);
    check("rst dwait", bus.dwait, 1);
    check("rst strobes", {bus.ramREN, bus.ramWEN}, 0);
    check("rst loads", {bus.iload, bus.dload}, 0);

    // 1: single icache read
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    #1;
    check("t1 idle ren", bus.ramREN, 0);
    tick();
    check("t1 ren", bus.ramREN, 1);
    check("t1 addr", bus.ramaddr, 64'h40);
    check("t1 iwait", bus.iwait, 1);
    tick();
    bus.ram_rdy = 1'b1;
    bus.ramload = 32'hDEADBEEF;
    #1;
    check("t1 done", bus.iwait, 0);
    check("t1 iload", bus.iload, 64'hDEADBEEF);
    tick();
    bus.ram_rdy = 1'b0;
    bus.iREN    = 1'b0;
    #1;
    check("t1 idle", bus.ramREN, 0);
    check("t1 iwait2", bus.iwait, 1);
    check("t1 iload0", bus.iload, 0);

    // 2: simultaneous requests, dcache first
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h44;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h80;
    #1;
    tick();
    check("t2 dgnt", {bus.ramREN, bus.ramWEN}, 2'b10);
    check("t2 daddr", bus.ramaddr, 64'h80);
    bus.ram_rdy = 1'b1;
    bus.ramload = 32'h55;
    #1;
    check("t2 ddone", bus.dwait, 0);
    check("t2 dload", bus.dload, 64'h55);
    check("t2 iwait", bus.iwait, 1);
    check("t2 iload0", bus.iload, 0);
    tick();
    bus.ram_rdy = 1'b0;
    bus.dREN    = 1'b0;
    #1;
    check("t2 gap", bus.ramREN, 0);
    check("t2 gap iw", bus.iwait, 1);
    tick();
    check("t2 ignt", bus.ramREN, 1);
    check("t2 iaddr", bus.ramaddr, 64'h44);
    bus.ram_rdy = 1'b1;
    #1;
    check("t2 idone", bus.iwait, 0);
    tick();
    bus.ram_rdy = 1'b0;
    bus.iREN    = 1'b0;
    #1;

    // 3: starvation guard, twice to show the counter restarts
    bus.iREN  = 1'b1;
    bus.dWEN  = 1'b1;
    bus.daddr = 32'h300;
    #1;
    run_starve(n_d, got_i);
    check("t3 dgrants", n_d, 4);
    check("t3 igrant", got_i, 1);
    run_starve(n_d, got_i);
    check("t3 dgrants2", n_d, 4);
    check("t3 igrant2", got_i, 1);
    bus.iREN = 1'b0;
    bus.dWEN = 1'b0;
    #1;

    // 4: read and write together, write wins
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h100;
    bus.dstore = 32'h12345678;
    #1;
    tick();
    check("t4 strobes", {bus.ramREN, bus.ramWEN}, 2'b01);
    check("t4 addr", bus.ramaddr, 64'h100);
    check("t4 store", bus.ramstore, 64'h12345678);
    check("t4 dwait", bus.dwait, 1);
    bus.ram_rdy = 1'b1;
    #1;
    check("t4 done", bus.dwait, 0);
    tick();
    bus.ram_rdy = 1'b0;
    bus.dREN    = 1'b0;
    bus.dWEN    = 1'b0;
    #1;

    // 5: reset during a dcache grant
    bus.dREN  = 1'b1;
    bus.daddr = 32'h200;
    #1;
    tick();
    check("t5 grant", bus.ramREN, 1);
    RST      = 1'b1;
    bus.dREN = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    check("t5 strobes", {bus.ramREN, bus.ramWEN}, 0);
    check("t5 dwait", bus.dwait, 1);
    bus.ram_rdy = 1'b1;
    bus.ramload = 32'hAA;
    #1;
    check("t5 late rdy", bus.dwait, 1);
    check("t5 dload0", bus.dload, 0);
    check("t5 late iw", bus.iwait, 1);
    tick();
    bus.ram_rdy = 1'b0;
    #1;
    check("t5 idle", {bus.ramREN, bus.ramWEN}, 0);

    // icache withdrawal before ram_rdy
    bus.iREN = 1'b1;
    #1;
    tick();
    bus.iREN = 1'b0;
    #1;
    check("wd grant", bus.ramREN, 1);
    tick();
    bus.ram_rdy = 1'b1;
    #1;
    check("wd drop", bus.ramREN, 0);
    check("wd iwait", bus.iwait, 1);
    tick();
    bus.ram_rdy = 1'b0;
    #1;

`ifdef ARB_STATS_EN
    // 6: statistics, two stalled cycles per transaction
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("t6 clr", {igc, dgc, stc}, 0);
    txn(1'b0);
    txn(1'b1);
    txn(1'b0);
    txn(1'b1);
    txn(1'b0);
    check("t6 igrant", igc, 3);
    check("t6 dgrant", dgc, 2);
    check("t6 stall", stc, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
